// File: rtl/button_ctrl.sv
// -----------------------------------------------------------------------------
// button_ctrl
//
// Purpose
//   Turns two raw, bouncing push buttons into clean control for a downstream
//   up/down counter.  Each button is synchronized into the clk domain,
//   qualified by its own debounce state machine and, on every accepted press,
//   produces a one-cycle pulse and toggles a level output:
//     btn_en  -> en_press pulse, toggles enable
//     btn_dir -> dir_press pulse, toggles dir (0 = up, 1 = down)
//
//   A press is accepted only after the synchronized button has been seen high
//   for DEB_CYCLES consecutive count edges.  A release must likewise be stable
//   low for DEB_CYCLES count edges before a new press can start qualifying, so
//   release bounce never turns into an extra press.
//
// Ports
//   clk        in   system clock, rising edge only
//   reset_n    in   asynchronous active-low reset; deassertion is expected to
//                   be synchronized to clk outside this block
//   btn_en     in   raw asynchronous button, high = pressed
//   btn_dir    in   raw asynchronous button, high = pressed
//   enable     out  registered count-enable level
//   dir        out  registered direction level
//   en_press   out  one-cycle pulse per accepted btn_en press
//   dir_press  out  one-cycle pulse per accepted btn_dir press
//
// Parameters
//   DEB_CYCLES debounce time in clk cycles, legal range 2 .. 2^27-1
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// btn_debounce_chk
//
// Purpose
//   Simulation-time invariants for one debounce channel.  Has no outputs and
//   adds no logic to the synthesized netlist.
//
// Ports
//   clk, reset_n  clock and asynchronous active-low reset
//   i_cnt         debounce counter of the channel
//   i_press       press pulse of the channel
//   i_level       toggling level of the channel
// -----------------------------------------------------------------------------
module btn_debounce_chk #(
    parameter int          CW      = 2,
    parameter logic [CW-1:0] CNT_MAX = '1
) (
    input logic          clk,
    input logic          reset_n,
    input logic [CW-1:0] i_cnt,
    input logic          i_press,
    input logic          i_level
);

    // The counter saturates at the qualification limit and never wraps.
    a_cnt_bound: assert property (@(posedge clk) disable iff (!reset_n)
        i_cnt <= CNT_MAX);

    // A press is always followed by at least one cycle in PRESSED, so two
    // pulses can never be back to back.
    a_press_single: assert property (@(posedge clk) disable iff (!reset_n)
        i_press |=> !i_press);

    // The level output only ever changes on the edge that fires the pulse.
    a_level_on_press: assert property (@(posedge clk) disable iff (!reset_n)
        (i_level != $past(i_level)) |-> i_press);

endmodule

// -----------------------------------------------------------------------------
// btn_debounce
//
// Purpose
//   One complete button channel: 2-flop synchronizer, four-state debounce
//   FSM, registered press pulse and registered toggling level.
//
// Ports
//   clk, reset_n  clock and asynchronous active-low reset
//   i_btn         raw asynchronous button input, high = pressed
//   o_press       one-cycle pulse on each accepted press (registered)
//   o_level       level that toggles on each accepted press (registered)
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 32'd1250000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_btn,
    output logic o_press,
    output logic o_level
);

    // Counter width: exactly enough bits to hold DEB_CYCLES-1.
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CYCLES - 32'd1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

    localparam logic [1:0] ST_RELEASED    = 2'd0;
    localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
    localparam logic [1:0] ST_PRESSED     = 2'd2;
    localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

    logic          r_sync1;
    logic          r_sync2;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_press;
    logic          r_level;

    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_fire;
    logic          w_btn_s;

    // The second synchronizer flop is the only view of the button the FSM uses.
    assign w_btn_s = r_sync2;

    // Two-flop synchronizer bringing the raw button into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce next-state, next-count and press-qualification decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fire      = 1'b0;
        case (r_state)
            ST_RELEASED: begin
                if (w_btn_s) begin
                    w_state_nxt = ST_PRESS_CHK;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = ST_RELEASED;
                    w_cnt_nxt   = CNT_ZERO;
                end
            end
            ST_PRESS_CHK: begin
                if (!w_btn_s) begin
                    // Bounce during qualification: drop back, nothing happens.
                    w_state_nxt = ST_RELEASED;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = CNT_ZERO;
                    w_fire      = 1'b1;
                end else begin
                    w_state_nxt = ST_PRESS_CHK;
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!w_btn_s) begin
                    w_state_nxt = ST_RELEASE_CHK;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    // Held button: stay here indefinitely, no repeat pulses.
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = CNT_ZERO;
                end
            end
            ST_RELEASE_CHK: begin
                if (w_btn_s) begin
                    // Release bounce: the button is still considered pressed.
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = ST_RELEASED;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = ST_RELEASE_CHK;
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                // Unreachable encoding: recover to the idle state.
                w_state_nxt = ST_RELEASED;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Debounce state and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RELEASED;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Registered press pulse and toggling level, updated on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_press <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_press <= w_fire;
            r_level <= r_level ^ w_fire;
        end
    end

    assign o_press = r_press;
    assign o_level = r_level;

    btn_debounce_chk #(
        .CW      (CW),
        .CNT_MAX (CNT_MAX)
    ) u_chk (
        .clk     (clk),
        .reset_n (reset_n),
        .i_cnt   (r_cnt),
        .i_press (r_press),
        .i_level (r_level)
    );

endmodule

// -----------------------------------------------------------------------------
// button_ctrl top: two fully independent button channels.
// -----------------------------------------------------------------------------
module button_ctrl #(
    parameter int unsigned DEB_CYCLES = 32'd1250000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_en,
    input  logic btn_dir,
    output logic enable,
    output logic dir,
    output logic en_press,
    output logic dir_press
);

    logic w_en_press;
    logic w_enable;
    logic w_dir_press;
    logic w_dir;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_en (
        .clk     (clk),
        .reset_n (reset_n),
        .i_btn   (btn_en),
        .o_press (w_en_press),
        .o_level (w_enable)
    );

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_dir (
        .clk     (clk),
        .reset_n (reset_n),
        .i_btn   (btn_dir),
        .o_press (w_dir_press),
        .o_level (w_dir)
    );

    // All four outputs come straight from channel flops.
    assign enable    = w_enable;
    assign dir       = w_dir;
    assign en_press  = w_en_press;
    assign dir_press = w_dir_press;

endmodule

// File: tb/tb_button_ctrl.sv
// -----------------------------------------------------------------------------
// tb_button_ctrl
//
// Directed bench for button_ctrl with DEB_CYCLES = 4, so a steady press takes
// effect on the 7th edge after the button is first sampled high.  Edges are
// counted from the first rising edge that samples the new input value;
// outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_button_ctrl;

    logic clk;
    logic reset_n;
    logic btn_en;
    logic btn_dir;
    logic enable;
    logic dir;
    logic en_press;
    logic dir_press;

    int n_checks;
    int n_errors;

    button_ctrl #(
        .DEB_CYCLES (32'd4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_en    (btn_en),
        .btn_dir   (btn_dir),
        .enable    (enable),
        .dir       (dir),
        .en_press  (en_press),
        .dir_press (dir_press)
    );

    // 100 MHz-style free-running clock; rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        int exp_dir;

        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        btn_en   = 1'b0;
        btn_dir  = 1'b0;

        // Reset state.
        step(1);
        chk("rst_enable",    32'(enable),    32'd0);
        chk("rst_dir",       32'(dir),       32'd0);
        chk("rst_en_press",  32'(en_press),  32'd0);
        chk("rst_dir_press", 32'(dir_press), 32'd0);

        // Steady btn_en press from edge 1: pulse on edge 7 only.
        reset_n = 1'b1;
        btn_en  = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step(1);
            chk("t1_en_press", 32'(en_press), (e == 7) ? 32'd1 : 32'd0);
            chk("t1_enable",   32'(enable),   (e >= 7) ? 32'd1 : 32'd0);
            chk("t1_dir",      32'(dir),      32'd0);
        end
        btn_en = 1'b0;
        step(12);

        // Glitch: 3 high, 1 low, then steady high; pulse 7 edges after the
        // last rise (edge 5 samples it), i.e. edge 11.
        for (int e = 1; e <= 14; e++) begin
            btn_en = (e == 4) ? 1'b0 : 1'b1;
            step(1);
            chk("t2_en_press", 32'(en_press), (e == 11) ? 32'd1 : 32'd0);
            chk("t2_enable",   32'(enable),   (e >= 11) ? 32'd0 : 32'd1);
        end
        btn_en = 1'b0;
        step(12);

        // Four clean btn_dir cycles of 10 high / 10 low.
        pulses  = 0;
        exp_dir = 0;
        for (int e = 1; e <= 80; e++) begin
            btn_dir = (((e - 1) % 20) < 10) ? 1'b1 : 1'b0;
            step(1);
            if ((e % 20) == 7) exp_dir = 1 - exp_dir;
            if (dir_press) pulses = pulses + 1;
            chk("t3_dir_press", 32'(dir_press), ((e % 20) == 7) ? 32'd1 : 32'd0);
            chk("t3_dir",       32'(dir),       32'(exp_dir));
            chk("t3_en_press",  32'(en_press),  32'd0);
        end
        chk("t3_pulse_count", 32'(pulses), 32'd4);
        chk("t3_dir_final",   32'(dir),    32'd0);

        // Both buttons raised on the same edge: simultaneous qualification.
        btn_en  = 1'b1;
        btn_dir = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step(1);
            chk("t4_en_press",  32'(en_press),  (e == 7) ? 32'd1 : 32'd0);
            chk("t4_dir_press", 32'(dir_press), (e == 7) ? 32'd1 : 32'd0);
            chk("t4_enable",    32'(enable),    (e >= 7) ? 32'd1 : 32'd0);
            chk("t4_dir",       32'(dir),       (e >= 7) ? 32'd1 : 32'd0);
        end
        btn_en  = 1'b0;
        btn_dir = 1'b0;
        step(12);

        // Long hold of btn_en: exactly one pulse, enable 1 -> 0.
        btn_en = 1'b1;
        pulses = 0;
        for (int e = 1; e <= 1000; e++) begin
            step(1);
            if (en_press) pulses = pulses + 1;
        end
        chk("t5_hold_pulses", 32'(pulses), 32'd1);
        chk("t5_hold_enable", 32'(enable), 32'd0);

        // Release bounce: 2 low, 1 high, then steady low -> no pulse.
        pulses = 0;
        for (int e = 1; e <= 33; e++) begin
            btn_en = (e == 3) ? 1'b1 : 1'b0;
            step(1);
            if (en_press) pulses = pulses + 1;
        end
        chk("t5_release_pulses", 32'(pulses), 32'd0);
        chk("t5_release_enable", 32'(enable), 32'd0);
        chk("t5_dir_kept",       32'(dir),    32'd1);

        // Reset in the middle of a btn_dir qualification, button kept high.
        btn_dir = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step(1);
            chk("t6_pre_dir_press", 32'(dir_press), 32'd0);
            chk("t6_pre_dir",       32'(dir),       32'd1);
        end
        reset_n = 1'b0;
        #1;
        chk("t6_rst_dir",       32'(dir),       32'd0);
        chk("t6_rst_enable",    32'(enable),    32'd0);
        chk("t6_rst_dir_press", 32'(dir_press), 32'd0);
        chk("t6_rst_en_press",  32'(en_press),  32'd0);
        step(1);
        reset_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step(1);
            chk("t6_dir_press", 32'(dir_press), (e == 7) ? 32'd1 : 32'd0);
            chk("t6_dir",       32'(dir),       (e >= 7) ? 32'd1 : 32'd0);
            chk("t6_enable",    32'(enable),    32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
